// File: rtl/reg_bank_nbit.sv
// Bank of DEPTH WIDTH-bit registers. Each cycle applies hold/load/increment/decrement to one
// register. Port A drives a tri-stated bus, port B is always driven, and zero/carry flags are registered.
module reg_bank_nbit #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned AW     = $clog2(DEPTH),
   parameter bit          BYPASS = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Data,
   input  logic [AW-1:0]    wr_addr,
   input  logic [1:0]       op,
   input  logic [AW-1:0]    rd_a,
   input  logic             enable,
   output tri logic [WIDTH-1:0] Q_a,
   input  logic [AW-1:0]    rd_b,
   output logic [WIDTH-1:0] Q_b,
   output logic             zero,
   output logic             carry
);

   localparam logic [1:0] OpHold = 2'b00;
   localparam logic [1:0] OpLoad = 2'b01;
   localparam logic [1:0] OpInc  = 2'b10;
   localparam logic [1:0] OpDec  = 2'b11;

   // One extra bit so DEPTH == 2**AW still fits for the range compare.
   localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;

   logic             wr_ok, rd_a_ok, rd_b_ok;
   logic             load_now;
   logic [WIDTH-1:0] cur_val, new_val;
   logic             new_carry;
   logic [WIDTH-1:0] q_a_val, q_b_val;

   assign wr_ok   = {1'b0, wr_addr} < DepthW;
   assign rd_a_ok = {1'b0, rd_a} < DepthW;
   assign rd_b_ok = {1'b0, rd_b} < DepthW;

   // Bypass only reflects a load that will actually commit (not during reset).
   assign load_now = BYPASS && !rst && (op == OpLoad) && wr_ok;

   always_comb begin
      regs_d    = regs_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      cur_val   = wr_ok ? regs_q[wr_addr] : '0;
      new_val   = cur_val;
      new_carry = 1'b0;
      case (op)
         OpLoad: new_val = Data;
         OpInc: begin
            new_val   = cur_val + 1'b1;
            new_carry = &cur_val;
         end
         OpDec: begin
            new_val   = cur_val - 1'b1;
            new_carry = ~|cur_val;
         end
         default: new_val = cur_val;
      endcase
      if (wr_ok && (op != OpHold)) begin
         regs_d[wr_addr] = new_val;
         zero_d          = (new_val == '0);
         carry_d         = new_carry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs_q[i] <= '0;
         end
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         regs_q  <= regs_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
      end
   end

   always_comb begin
      q_a_val = '0;
      if (rd_a_ok) begin
         q_a_val = (load_now && (rd_a == wr_addr)) ? Data : regs_q[rd_a];
      end
   end

   always_comb begin
      q_b_val = '0;
      if (rd_b_ok) begin
         q_b_val = (load_now && (rd_b == wr_addr)) ? Data : regs_q[rd_b];
      end
   end

   assign Q_a   = enable ? q_a_val : {WIDTH{1'bz}};
   assign Q_b   = q_b_val;
   assign zero  = zero_q;
   assign carry = carry_q;

endmodule
